// File: rtl/add_i8v4_pkg.sv
// ----------------------------------------------------------------------------
// add_i8v4_pkg
// Shared constants and types for the four-lane signed 8-bit vector adder.
//   LANES  : number of independent lanes (4)
//   LANE_W : width of one lane in bits (8)
//   lane_t : one two's-complement lane value
//   vec_t  : all lanes packed together, lane 0 in the least significant slot
// ----------------------------------------------------------------------------
package add_i8v4_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;

endpackage : add_i8v4_pkg

// File: rtl/add_i8v4_lane.sv
// ----------------------------------------------------------------------------
// add_i8v4_lane
// One 8-bit two's-complement wrap-around adder lane: y = (a + b) mod 256.
// No saturation, no overflow flag, no carry-out.
//
// Configuration macro: ADD_I8V4_OUT_REG_EN
//   undefined : y is a purely combinational function of a and b; clock and
//               reset are ignored.
//   defined   : y is registered (1 cycle latency) with asynchronous,
//               active-high reset clearing it to 0.
//
// Ports
//   clock : system clock (register build only)
//   reset : asynchronous active-high reset (register build only)
//   a, b  : lane operands, two's complement
//   y     : lane sum, two's complement, wrapped to 8 bits
// ----------------------------------------------------------------------------
module add_i8v4_lane
    import add_i8v4_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  lane_t a,
    input  lane_t b,
    output lane_t y
);

    // Sign-extend both operands, add at full width, then keep the low bits.
    // Dropping the top bit is exactly the modulo-256 wrap; the signed and
    // unsigned readings of the kept bits are identical.
    function automatic lane_t wrap_add(input logic signed [LANE_W-1:0] x,
                                       input logic signed [LANE_W-1:0] z);
        logic signed [LANE_W:0] full;
        full = (LANE_W+1)'(x) + (LANE_W+1)'(z);
        return full[LANE_W-1:0];
    endfunction

    logic signed [LANE_W-1:0] a_p0;
    logic signed [LANE_W-1:0] b_p0;
    lane_t                    sum_p0;

    // ---- stage p0: combinational add ----
    assign a_p0   = a;
    assign b_p0   = b;
    assign sum_p0 = wrap_add(a_p0, b_p0);

`ifdef ADD_I8V4_OUT_REG_EN
    lane_t y_p1;

    // ---- stage p1: output register ----
    // Reset must clear the visible output immediately, so the lane sum
    // register carries the asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= sum_p0;
        end
    end

    assign y = y_p1;
`else
    // Clock and reset have no role in the combinational build.
    logic unused_ctrl;
    assign unused_ctrl = clock ^ reset;

    assign y = sum_p0;
`endif

endmodule : add_i8v4_lane

// File: rtl/add_i8v4.sv
// ----------------------------------------------------------------------------
// add_i8v4
// Four-lane signed 8-bit vector adder: y_i = (a_i + b_i) mod 256, i = 0..3.
// Lanes are fully independent; no carry passes between lanes.
//
// Configuration macro: ADD_I8V4_OUT_REG_EN
//   undefined (default) : combinational, zero latency, reset unused.
//   defined             : one output register per lane, latency 1 clock,
//                         asynchronous active-high reset to 0.
//
// Ports
//   clock      : system clock (register build only)
//   reset      : asynchronous active-high reset (register build only)
//   a_0..a_3   : lane operands A, two's complement, 8 bits each
//   b_0..b_3   : lane operands B, two's complement, 8 bits each
//   y_0..y_3   : lane sums, two's complement, 8 bits each
// ----------------------------------------------------------------------------
module add_i8v4
    import add_i8v4_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  a_0,
    input  logic [7:0]  a_1,
    input  logic [7:0]  a_2,
    input  logic [7:0]  a_3,
    input  logic [7:0]  b_0,
    input  logic [7:0]  b_1,
    input  logic [7:0]  b_2,
    input  logic [7:0]  b_3,
    output logic [7:0]  y_0,
    output logic [7:0]  y_1,
    output logic [7:0]  y_2,
    output logic [7:0]  y_3
);

    vec_t a_vec;
    vec_t b_vec;
    vec_t y_vec;

    // Discrete lane ports packed so the lanes can be generated uniformly.
    assign a_vec = {a_3, a_2, a_1, a_0};
    assign b_vec = {b_3, b_2, b_1, b_0};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        add_i8v4_lane u_lane (
            .clock (clock),
            .reset (reset),
            .a     (a_vec[i]),
            .b     (b_vec[i]),
            .y     (y_vec[i])
        );
    end

    assign y_0 = y_vec[0];
    assign y_1 = y_vec[1];
    assign y_2 = y_vec[2];
    assign y_3 = y_vec[3];

endmodule : add_i8v4

// File: tb/tb_add_i8v4.sv
// ----------------------------------------------------------------------------
// tb_add_i8v4
// Self-checking bench for add_i8v4. Handles both the combinational build and
// the registered build (ADD_I8V4_OUT_REG_EN) by adjusting when results are
// sampled.
// ----------------------------------------------------------------------------
module tb_add_i8v4;

    logic       clock;
    logic       reset;
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [7:0] y [4];

    int checks;
    int failures;

    typedef struct {
        string           name;
        logic [3:0][7:0] va;
        logic [3:0][7:0] vb;
        logic [3:0][7:0] vy;
    } vec_rec_t;

    vec_rec_t tbl[$];

`ifdef ADD_I8V4_OUT_REG_EN
    localparam bit REG_BUILD = 1'b1;
`else
    localparam bit REG_BUILD = 1'b0;
`endif

    add_i8v4 dut (
        .clock (clock),
        .reset (reset),
        .a_0   (a[0]),
        .a_1   (a[1]),
        .a_2   (a[2]),
        .a_3   (a[3]),
        .b_0   (b[0]),
        .b_1   (b[1]),
        .b_2   (b[2]),
        .b_3   (b[3]),
        .y_0   (y[0]),
        .y_1   (y[1]),
        .y_2   (y[2]),
        .y_3   (y[3])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int lane,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane%0d got=%02h exp=%02h", nm, lane, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0][7:0] exp);
        for (int i = 0; i < 4; i++) chk(nm, i, y[i], exp[i]);
    endtask

    task automatic drive(input logic [3:0][7:0] va, input logic [3:0][7:0] vb);
        for (int i = 0; i < 4; i++) begin
            a[i] = va[i];
            b[i] = vb[i];
        end
    endtask

    // Wait until the result of the currently driven inputs is visible.
    task automatic settle();
        if (REG_BUILD) begin
            @(posedge clock);
            #1;
        end else begin
            #1;
        end
    endtask

    task automatic add_rec(input string nm, input logic [3:0][7:0] va,
                           input logic [3:0][7:0] vb, input logic [3:0][7:0] vy);
        vec_rec_t r;
        r.name = nm;
        r.va   = va;
        r.vb   = vb;
        r.vy   = vy;
        tbl.push_back(r);
    endtask

    logic [3:0][7:0] mix_a, mix_b, mix_y;
    logic [3:0][7:0] ta, tb_, ty;
    logic [7:0]      ov_a [4];
    logic [7:0]      ov_b [4];
    logic [7:0]      ov_y [4];

    initial begin
        checks   = 0;
        failures = 0;

        // Mixed lanes: a = [-4,2,2,1], b = [1,3,0,1] -> y = [-3,5,2,2]
        mix_a = {8'h01, 8'h02, 8'h02, 8'hFC};
        mix_b = {8'h01, 8'h00, 8'h03, 8'h01};
        mix_y = {8'h02, 8'h02, 8'h05, 8'hFD};

        // Overflow cases: 127+1, -128+-128, -1+1, -128+127
        ov_a = '{8'h7F, 8'h80, 8'hFF, 8'h80};
        ov_b = '{8'h01, 8'h80, 8'h01, 8'h7F};
        ov_y = '{8'h80, 8'h00, 8'h00, 8'hFF};

        add_rec("mixed", mix_a, mix_b, mix_y);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) begin
                    ta[j]  = 8'(8'h10 + j);
                    tb_[j] = 8'h20;
                    ty[j]  = 8'(8'h30 + j);
                end
                ta[k]  = ov_a[c];
                tb_[k] = ov_b[c];
                ty[k]  = ov_y[c];
                add_rec($sformatf("ovf_l%0d_c%0d", k, c), ta, tb_, ty);
            end
        end
        add_rec("isolation", {8'h00, 8'h00, 8'h00, 8'hFF},
                             {8'h00, 8'h00, 8'h00, 8'h01},
                             {8'h00, 8'h00, 8'h00, 8'h00});

        // ---- reset with inputs held ----
        reset = 1'b1;
        drive(mix_a, mix_b);
        #3;
        if (REG_BUILD) chk_all("reset_state", '0);
        else           chk_all("reset_state_comb", mix_y);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        if (REG_BUILD) begin
            chk_all("post_reset_early", '0);
            @(posedge clock);
            #1;
        end
        chk_all("post_reset_mixed", mix_y);

        // ---- table-driven vectors ----
        foreach (tbl[n]) begin
            @(negedge clock);
            drive(tbl[n].va, tbl[n].vb);
            settle();
            chk_all(tbl[n].name, tbl[n].vy);
        end

        if (!REG_BUILD) begin
            // ---- combinational tracking, reset ignored ----
            @(negedge clock);
            drive({8'h01, 8'h02, 8'h02, 8'hFC}, {8'h01, 8'h05, 8'h03, 8'h01});
            #1;
            chk("track_before", 2, y[2], 8'h07);
            a[2] = 8'd10;
            #1;
            chk("track_same_cycle", 2, y[2], 8'h0F);
            reset = 1'b1;
            #1;
            chk("track_reset_now", 2, y[2], 8'h0F);
            @(posedge clock);
            #1;
            chk("track_reset_edge", 2, y[2], 8'h0F);
            chk("track_reset_l0", 0, y[0], 8'hFD);
            @(negedge clock);
            reset = 1'b0;
        end else begin
            // ---- reset mid-stream ----
            @(negedge clock);
            drive(mix_a, mix_b);
            @(posedge clock);
            #1;
            chk_all("mid_before", mix_y);
            #2;
            reset = 1'b1;
            #1;
            chk_all("mid_reset_now", '0);
            @(posedge clock);
            #1;
            chk_all("mid_reset_edge", '0);
            @(negedge clock);
            reset = 1'b0;
            #1;
            chk_all("mid_release_hold", '0);
            @(posedge clock);
            #1;
            chk_all("mid_release_sum", mix_y);
        end

        // ---- random vectors ----
        for (int n = 0; n < 10000; n++) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) begin
                ta[i]  = 8'($urandom_range(0, 255));
                tb_[i] = 8'($urandom_range(0, 255));
                ty[i]  = 8'((16'(ta[i]) + 16'(tb_[i])) & 16'h00FF);
            end
            drive(ta, tb_);
            settle();
            chk_all("random", ty);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_add_i8v4
